dmemwrite: RTL

Store-side data-memory formatter and write buffer. Takes a store from the execute/memory stage (address, rs2 data, funct3), builds the word-aligned address, lane-replicated write data and 4-bit byte strobe for SB/SH/SW, and queues it in a small FIFO that drains to data memory over a valid/ready handshake. It is the write-direction counterpart of the load-data select/extend path and sits between the pipeline's store port and the dmem write port.

---
 rtl/dmemwrite_if.sv | 31 +++
 rtl/dmemwrite.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmemwrite_if.sv
// dmemwrite_if: store-port and dmem write-port bundle for the store formatter/write buffer.
// slave  = the dmemwrite block's view; master = the surrounding pipeline/memory view.
interface dmemwrite_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [2:0]    funct3;
  logic          st_err;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  st_valid, st_addr, st_data, funct3, mem_ready,
    output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wstrb, empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, funct3, mem_ready,
    input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wstrb, empty, count
  );
endinterface

// File: rtl/dmemwrite.sv
// dmemwrite: store-side formatter and write buffer.
// Formats SB/SH/SW into a word address, lane-replicated data and byte strobes,
// queues legal stores in a DEPTH-entry FIFO and drains them over mem_valid/mem_ready.
// Bad stores (misaligned or unknown funct3) are consumed, dropped, and flagged on st_err.
// Optional feature macro: DMEMWRITE_BYPASS_EN -- an empty buffer forwards a legal store
// straight to mem_* in the same cycle when memory is ready.
module dmemwrite #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  dmemwrite_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        ok;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } fmt_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  // Build the aligned address, replicated data and strobes; ok=0 flags a store to drop.
  function automatic fmt_t format_store(input logic [31:0] addr,
                                        input logic [31:0] data,
                                        input logic [2:0]  f3);
    fmt_t f;
    f.ok    = 1'b0;
    f.addr  = {addr[31:2], 2'b00};
    f.wdata = 32'h0000_0000;
    f.wstrb = 4'b0000;
    case (f3)
      3'b000: begin
        f.ok    = 1'b1;
        f.wstrb = 4'b0001 << addr[1:0];
        f.wdata = {4{data[7:0]}};
      end
      3'b001: begin
        if (addr[0] == 1'b0) begin
          f.ok    = 1'b1;
          f.wstrb = addr[1] ? 4'b1100 : 4'b0011;
          f.wdata = {2{data[15:0]}};
        end else begin
          f.ok    = 1'b0;
        end
      end
      3'b010: begin
        if (addr[1:0] == 2'b00) begin
          f.ok    = 1'b1;
          f.wstrb = 4'b1111;
          f.wdata = data;
        end else begin
          f.ok    = 1'b0;
        end
      end
      default: begin
        f.ok = 1'b0;
      end
    endcase
    return f;
  endfunction

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        st_err_q, st_err_d;
  entry_t      buf_q [DEPTH];
  entry_t      buf_d [DEPTH];

  fmt_t        fmt_s;
  entry_t      head_s;
  logic        empty_s;
  logic        full_s;
  logic        accept_s;
  logic        bypass_s;
  logic        enq_s;
  logic        deq_s;
  logic        mem_valid_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [3:0]  mem_wstrb_s;

  // Handshake decode: accept/enqueue/dequeue/bypass decisions from current state and inputs.
  always_comb begin
    fmt_s    = format_store(bus.st_addr, bus.st_data, bus.funct3);
    empty_s  = (wptr_q == rptr_q);
    full_s   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    accept_s = bus.st_valid && !full_s;
`ifdef DMEMWRITE_BYPASS_EN
    // Forward only from an empty buffer so ordering with queued stores is never broken.
    bypass_s = empty_s && accept_s && fmt_s.ok && bus.mem_ready;
`else
    bypass_s = 1'b0;
`endif
    enq_s    = accept_s && fmt_s.ok && !bypass_s;
    deq_s    = !empty_s && bus.mem_ready;
  end

  // Next-state for pointers, storage and the error pulse.
  always_comb begin
    buf_d = buf_q;
    if (enq_s) begin
      wptr_d = wptr_q + (AW+1)'(1);
      buf_d[wptr_q[AW-1:0]] = '{addr: fmt_s.addr, wdata: fmt_s.wdata, wstrb: fmt_s.wstrb};
    end else begin
      wptr_d = wptr_q;
    end
    if (deq_s) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
    st_err_d = accept_s && !fmt_s.ok;
  end

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      st_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      st_err_q <= st_err_d;
      buf_q    <= buf_d;
    end
  end

  // Write-port mux: bypassed store, else FIFO head, else all zeros.
  always_comb begin
    head_s = buf_q[rptr_q[AW-1:0]];
    if (bypass_s) begin
      mem_valid_s = 1'b1;
      mem_addr_s  = fmt_s.addr;
      mem_wdata_s = fmt_s.wdata;
      mem_wstrb_s = fmt_s.wstrb;
    end else if (!empty_s) begin
      mem_valid_s = 1'b1;
      mem_addr_s  = head_s.addr;
      mem_wdata_s = head_s.wdata;
      mem_wstrb_s = head_s.wstrb;
    end else begin
      mem_valid_s = 1'b0;
      mem_addr_s  = 32'h0000_0000;
      mem_wdata_s = 32'h0000_0000;
      mem_wstrb_s = 4'b0000;
    end
  end

  assign bus.st_ready  = !full_s;
  assign bus.st_err    = st_err_q;
  assign bus.empty     = empty_s;
  assign bus.count     = wptr_q - rptr_q;
  assign bus.mem_valid = mem_valid_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.mem_wstrb = mem_wstrb_s;

endmodule
